// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard controller for the 5-stage pipeline.
// - Per-source EX forwarding selects: 00 regfile, 01 MEM ALU, 10 WB, 11 mc result.
// - Load-use detection against the EX-stage load.
// - Scoreboard for one in-flight multi-cycle (mul/div) op of fixed latency MC_LAT.
//   It stalls RAW-dependent and structurally conflicting ID instructions.
// Optional build macro: MC_FWD_EN.
// - Defined: the mc result forwards with code 11 on the mc_done cycle, and the
//   RAW stall releases one cycle earlier.
// - Undefined: code 11 is never produced, and a dependant waits until after mc_done
//   and then reads the regfile.

module fwd_hazard_ctrl #(
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned MC_LAT  = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      pipe_en,
    input  logic                      flush,
    input  logic [NUM_SRC*REG_AW-1:0] id_src,
    input  logic [NUM_SRC-1:0]        id_src_use,
    input  logic                      id_is_mc,
    input  logic [NUM_SRC*REG_AW-1:0] ex_src,
    input  logic [NUM_SRC-1:0]        ex_src_use,
    input  logic [REG_AW-1:0]         ex_wsel,
    input  logic                      ex_regWr,
    input  logic                      ex_dmemren,
    input  logic [REG_AW-1:0]         mem_wsel,
    input  logic                      mem_regWr,
    input  logic                      mem_dmemren,
    input  logic [REG_AW-1:0]         wb_wsel,
    input  logic                      wb_regWr,
    input  logic                      mc_issue,
    input  logic [REG_AW-1:0]         mc_wsel_i,
    output logic [2*NUM_SRC-1:0]      fward,
    output logic                      stall_id,
    output logic                      bubble_ex,
    output logic                      mc_busy,
    output logic                      mc_done,
    output logic [REG_AW-1:0]         mc_wsel
);

    localparam int unsigned CntW = $clog2(MC_LAT);

    typedef enum logic [0:0] {StIdle, StMcBusy} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [REG_AW-1:0]   mc_wsel_q, mc_wsel_d;

    logic                issue_ok;
    logic                load_use;
    logic                mc_raw_hit;
    logic                mc_raw_win;
    logic                mc_struct;

    // An issue is only accepted while the pipeline advances and is not being squashed.
    assign issue_ok = mc_issue & pipe_en & ~flush;

    assign mc_busy  = (state_q == StMcBusy);
    assign mc_done  = mc_busy & (cnt_q == '0);
    assign mc_wsel  = mc_wsel_q;

    // Per-source EX forwarding select; register 0 never forwards.
    always_comb begin
        fward = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (ex_src_use[i] && (ex_src[i*REG_AW +: REG_AW] != '0)) begin
                if (mem_regWr && !mem_dmemren && (mem_wsel == ex_src[i*REG_AW +: REG_AW])) begin
                    fward[2*i +: 2] = 2'b01;
                end else if (wb_regWr && (wb_wsel == ex_src[i*REG_AW +: REG_AW])) begin
                    fward[2*i +: 2] = 2'b10;
                end
`ifdef MC_FWD_EN
                // mc result has top priority; assigned last so it overrides MEM/WB.
                if (mc_done && (mc_wsel_q == ex_src[i*REG_AW +: REG_AW])) begin
                    fward[2*i +: 2] = 2'b11;
                end
`endif
            end
        end
    end

    // ID-source comparisons against the EX load and the in-flight mc destination.
    always_comb begin
        load_use   = 1'b0;
        mc_raw_hit = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (id_src_use[i] && (id_src[i*REG_AW +: REG_AW] != '0)) begin
                if (ex_regWr && ex_dmemren && (ex_wsel == id_src[i*REG_AW +: REG_AW])) begin
                    load_use = 1'b1;
                end
                if (mc_wsel_q == id_src[i*REG_AW +: REG_AW]) begin
                    mc_raw_hit = 1'b1;
                end
            end
        end
    end

`ifdef MC_FWD_EN
    // Release one cycle early so the dependant reaches EX on the mc_done cycle.
    assign mc_raw_win = (cnt_q > CntW'(1));
`else
    assign mc_raw_win = (cnt_q != '0);
`endif

    assign mc_struct = id_is_mc & mc_busy & (cnt_q != '0);

    // Stalls do not depend on pipe_en so a frozen pipe keeps its hazard view.
    always_comb begin
        stall_id  = load_use | (mc_busy & mc_raw_hit & mc_raw_win) | mc_struct;
        bubble_ex = stall_id;
    end

    // Scoreboard next state: count down while busy, reload on a back-to-back issue at done.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mc_wsel_d = mc_wsel_q;
        unique case (state_q)
            StIdle: begin
                if (issue_ok) begin
                    state_d   = StMcBusy;
                    cnt_d     = CntW'(MC_LAT - 1);
                    mc_wsel_d = mc_wsel_i;
                end
            end
            StMcBusy: begin
                if (cnt_q != '0) begin
                    // An issue here is blocked upstream by the structural stall.
                    cnt_d = cnt_q - CntW'(1);
                end else if (issue_ok) begin
                    cnt_d     = CntW'(MC_LAT - 1);
                    mc_wsel_d = mc_wsel_i;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Scoreboard state; reset discards any in-flight op.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            mc_wsel_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mc_wsel_q <= mc_wsel_d;
        end
    end

endmodule
